// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The optional FETCH_BYPASS_EN build is selected in inst_fetch_queue.sv.
package fetch_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int INST_BYTES   = 4;

    typedef logic [63:0] inst_id_t;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] addr;
        logic [DEFAULT_XLEN-1:0] inst;
    } fetch_entry_t;

    // Pointer width including the wrap bit; a depth of 1 still gets a 1-bit index.
    function automatic int ptr_w(input int depth);
        return ((depth > 1) ? $clog2(depth) : 1) + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Backend, IF/ID and instruction-memory handshakes of the fetch queue.
// The queue itself uses the master modport, its environment the slave modport.
interface inst_fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
);
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;

    logic            iresp_valid;
    logic            iresp_ready;
    logic [XLEN-1:0] iresp_addr;
    logic [XLEN-1:0] iresp_inst;
    inst_id_t        iresp_inst_id;

    logic            memreq_valid;
    logic            memreq_ready;
    logic [XLEN-1:0] memreq_addr;

    logic            memresp_valid;
    logic [XLEN-1:0] memresp_addr;
    logic [XLEN-1:0] memresp_inst;

    modport master (
        input  ireq_valid, ireq_addr,
        output iresp_valid, iresp_addr, iresp_inst, iresp_inst_id,
        input  iresp_ready,
        output memreq_valid, memreq_addr,
        input  memreq_ready,
        input  memresp_valid, memresp_addr, memresp_inst
    );

    modport slave (
        output ireq_valid, ireq_addr,
        input  iresp_valid, iresp_addr, iresp_inst, iresp_inst_id,
        output iresp_ready,
        input  memreq_valid, memreq_addr,
        output memreq_ready,
        output memresp_valid, memresp_addr, memresp_inst
    );

endinterface

// File: rtl/fetch_ring_buffer.sv
// Generic synchronous FIFO with wrap-bit pointers, flush, occupancy count and
// a read port at an offset from the head.
module fetch_ring_buffer
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_w(DEPTH),
    localparam int AW   = PW - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic [AW-1:0]    rd_offset,
    output logic [WIDTH-1:0] rd_data,
    output logic [PW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [0:(1 << AW)-1];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign count   = tail - head;
    assign empty   = (head == tail);
    assign full    = (count == PW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[head[AW-1:0] + rd_offset];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (flush) begin
                head <= tail;
            end else if (do_pop) begin
                head <= head + PW'(1);
            end
            if (do_push) begin
                tail <= tail + PW'(1);
            end
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Multi-outstanding instruction fetch queue between IF/ID and instruction memory.
// Optional FETCH_BYPASS_EN presents a live response directly when the queue is empty.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH           = 16,
    parameter int              MAX_OUTSTANDING = 4,
    parameter int              XLEN            = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_queue_if.master bus
);

    localparam int QCW = ptr_w(DEPTH);
    localparam int QAW = QCW - 1;
    localparam int ACW = ptr_w(MAX_OUTSTANDING);
    localparam int AAW = ACW - 1;

    if (XLEN != DEFAULT_XLEN) begin : g_xlen_guard
        $error("inst_fetch_queue: XLEN must equal fetch_pkg::DEFAULT_XLEN");
    end

    logic            started;
    logic [XLEN-1:0] pc;
    logic [ACW-1:0]  drop_cnt;
    inst_id_t        inst_id;

    fetch_entry_t    q_head;
    fetch_entry_t    q_push_data;
    logic [QCW-1:0]  q_count;
    logic            q_empty;
    logic            q_push;
    logic            deq;

    logic [XLEN-1:0] a_peek;
    logic [ACW-1:0]  a_count;
    logic            a_empty;

    logic [ACW-1:0]  live_cnt;
    logic            redirect_hit;
    logic            flush;
    logic            credit_ok;
    logic            issue;
    logic            mem_fire;
    logic            resp_pop;
    logic            resp_match;

    assign live_cnt = a_count - drop_cnt;

    // a_peek is the oldest live request: the entry just past the ones still to be dropped.
    assign redirect_hit = q_empty && (live_cnt != '0) && (a_peek == bus.ireq_addr);
    assign flush        = bus.ireq_valid && !redirect_hit;

    assign credit_ok = (a_count < ACW'(MAX_OUTSTANDING)) &&
                       ((32'(q_count) + 32'(a_count)) < 32'(DEPTH));
    assign issue     = started && !flush && credit_ok;
    assign mem_fire  = issue && bus.memreq_ready;

    assign resp_pop   = bus.memresp_valid && !a_empty;
    assign resp_match = resp_pop && (drop_cnt == '0) && (bus.memresp_addr == a_peek);

    assign q_push_data = '{addr: bus.memresp_addr, inst: bus.memresp_inst};

`ifdef FETCH_BYPASS_EN
    logic bypass;

    assign bypass           = q_empty && resp_match && !flush;
    assign bus.iresp_valid  = !q_empty || bypass;
    assign bus.iresp_addr   = q_empty ? bus.memresp_addr : q_head.addr;
    assign bus.iresp_inst   = q_empty ? bus.memresp_inst : q_head.inst;
    assign deq              = bus.iresp_valid && bus.iresp_ready && !flush;
    assign q_push           = resp_match && !flush && !(bypass && bus.iresp_ready);
`else
    assign bus.iresp_valid  = !q_empty;
    assign bus.iresp_addr   = q_head.addr;
    assign bus.iresp_inst   = q_head.inst;
    assign deq              = !q_empty && bus.iresp_ready && !flush;
    assign q_push           = resp_match && !flush;
`endif

    assign bus.iresp_inst_id = inst_id;
    assign bus.memreq_valid  = issue;
    assign bus.memreq_addr   = pc;

    fetch_ring_buffer #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (deq),
        .rd_offset ({QAW{1'b0}}),
        .rd_data   (q_head),
        .count     (q_count),
        .empty     (q_empty)
    );

    fetch_ring_buffer #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (mem_fire),
        .push_data (pc),
        .pop       (resp_pop),
        .rd_offset (drop_cnt[AAW-1:0]),
        .rd_data   (a_peek),
        .count     (a_count),
        .empty     (a_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started  <= 1'b0;
            pc       <= RESET_PC;
            drop_cnt <= '0;
            inst_id  <= '0;
        end else begin
            started <= 1'b1;
            if (flush) begin
                // Every request still in flight after this cycle is stale.
                pc       <= bus.ireq_addr;
                drop_cnt <= a_count - ACW'(resp_pop);
                inst_id  <= inst_id + 64'd1;
            end else begin
                if (mem_fire) begin
                    pc <= pc + XLEN'(INST_BYTES);
                end
                if (resp_pop && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - ACW'(1);
                end
                if (deq) begin
                    inst_id <= inst_id + 64'd1;
                end
            end
        end
    end

    FETCH_ASSERT: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.memresp_valid && (drop_cnt == '0)) |-> (!a_empty && (bus.memresp_addr == a_peek)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (default build, DEPTH=16, MAX_OUTSTANDING=4).
// Memory model returns responses in order, one cycle after acceptance unless held.
module tb_inst_fetch_queue;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.XLEN(32)) bus ();

    inst_fetch_queue #(
        .DEPTH           (16),
        .MAX_OUTSTANDING (4),
        .XLEN            (32),
        .RESET_PC        (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [63:0] id;
    } del_t;

    typedef struct {
        bit          mreq_rdy;
        bit          iresp_rdy;
        bit          exp_mv;
        logic [31:0] exp_maddr;
        bit          exp_iv;
        logic [31:0] exp_iaddr;
        logic [63:0] exp_id;
    } vec_t;

    pend_t pend[$];
    del_t  deliv[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    hold = 1'b0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive the memory response for the current cycle, then let outputs settle.
    task automatic settle();
        bus.memresp_valid = 1'b0;
        bus.memresp_addr  = '0;
        bus.memresp_inst  = '0;
        if (rst_n && !hold && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.memresp_valid = 1'b1;
            bus.memresp_addr  = pend[0].addr;
            bus.memresp_inst  = inst_of(pend[0].addr);
        end
        #1;
    endtask

    // Record this cycle's handshakes and move to the next negedge.
    task automatic advance();
        if (rst_n) begin
            if (bus.memresp_valid) void'(pend.pop_front());
            if (bus.memreq_valid && bus.memreq_ready)
                pend.push_back('{addr: bus.memreq_addr, due: cyc + 1});
            if (bus.iresp_valid && bus.iresp_ready && !bus.ireq_valid)
                deliv.push_back('{addr: bus.iresp_addr, inst: bus.iresp_inst, id: bus.iresp_inst_id});
        end else begin
            pend.delete();
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.ireq_valid   = 1'b0;
        bus.ireq_addr    = '0;
        bus.iresp_ready  = 1'b0;
        bus.memreq_ready = 1'b0;
        hold             = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        deliv.delete();
        pend.delete();
    endtask

    task automatic wait_deliv(input int n, input string name);
        for (int i = 0; i < 80 && deliv.size() < n; i++) tick();
        check(name, 64'(deliv.size() >= n), 64'd1);
    endtask

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_next;
        logic [31:0] tgt;
        bit          redir;
        int          issued;
        int          total;

        bus.ireq_valid    = 1'b0;
        bus.ireq_addr     = '0;
        bus.iresp_ready   = 1'b0;
        bus.memreq_ready  = 1'b0;
        bus.memresp_valid = 1'b0;
        bus.memresp_addr  = '0;
        bus.memresp_inst  = '0;

        //           mrdy irdy mv  maddr       iv  iaddr       id
        vecs[0]  = '{1, 1, 0, 32'h0,  0, 32'h0,  64'd0};
        vecs[1]  = '{1, 1, 1, 32'h0,  0, 32'h0,  64'd0};
        vecs[2]  = '{1, 1, 1, 32'h4,  0, 32'h0,  64'd0};
        vecs[3]  = '{1, 1, 1, 32'h8,  1, 32'h0,  64'd0};
        vecs[4]  = '{1, 1, 1, 32'hC,  1, 32'h4,  64'd1};
        vecs[5]  = '{1, 1, 1, 32'h10, 1, 32'h8,  64'd2};
        vecs[6]  = '{1, 1, 1, 32'h14, 1, 32'hC,  64'd3};
        vecs[7]  = '{0, 1, 1, 32'h18, 1, 32'h10, 64'd4};
        vecs[8]  = '{1, 1, 1, 32'h18, 1, 32'h14, 64'd5};
        vecs[9]  = '{1, 1, 1, 32'h1C, 0, 32'h0,  64'd6};
        vecs[10] = '{1, 1, 1, 32'h20, 1, 32'h18, 64'd6};

        @(negedge clk);

        // Reset release and steady streaming with a 1-cycle memory.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.memreq_ready = vecs[i].mreq_rdy;
            bus.iresp_ready  = vecs[i].iresp_rdy;
            settle();
            check($sformatf("vec%0d_memreq_valid", i), 64'(bus.memreq_valid), 64'(vecs[i].exp_mv));
            if (vecs[i].exp_mv)
                check($sformatf("vec%0d_memreq_addr", i), 64'(bus.memreq_addr), 64'(vecs[i].exp_maddr));
            check($sformatf("vec%0d_iresp_valid", i), 64'(bus.iresp_valid), 64'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                check($sformatf("vec%0d_iresp_addr", i), 64'(bus.iresp_addr), 64'(vecs[i].exp_iaddr));
                check($sformatf("vec%0d_iresp_inst", i), 64'(bus.iresp_inst), 64'(inst_of(vecs[i].exp_iaddr)));
            end
            check($sformatf("vec%0d_inst_id", i), bus.iresp_inst_id, vecs[i].exp_id);
            advance();
        end

        // Back-pressure: credits stop issue at DEPTH, then drain in order.
        do_reset();
        bus.memreq_ready = 1'b1;
        issued = 0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (bus.memreq_valid && bus.memreq_ready) issued++;
            advance();
        end
        check("fill_issued", 64'(issued), 64'd16);
        settle();
        check("fill_memreq_stalled", 64'(bus.memreq_valid), 64'd0);
        check("fill_head_addr", 64'(bus.iresp_addr), 64'h0);
        advance();
        bus.iresp_ready = 1'b1;
        wait_deliv(16, "drain_count");
        for (int i = 0; i < 16 && i < deliv.size(); i++) begin
            check($sformatf("drain%0d_addr", i), 64'(deliv[i].addr), 64'(32'(i * 4)));
            check($sformatf("drain%0d_id", i), deliv[i].id, 64'(i));
        end

        // Mispredict with three requests in flight: stale responses are dropped.
        do_reset();
        hold = 1'b1;
        bus.iresp_ready = 1'b1;
        tick();
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 32'h10;
        tick();
        bus.ireq_valid   = 1'b0;
        bus.memreq_ready = 1'b1;
        repeat (3) tick();
        bus.memreq_ready = 1'b0;
        check("redir_inflight", 64'(pend.size()), 64'd3);
        bus.ireq_valid   = 1'b1;
        bus.ireq_addr    = 32'h100;
        bus.memreq_ready = 1'b1;
        settle();
        check("redir_no_issue", 64'(bus.memreq_valid), 64'd0);
        advance();
        bus.ireq_valid = 1'b0;
        settle();
        check("redir_queue_empty", 64'(bus.iresp_valid), 64'd0);
        check("redir_id_bump", bus.iresp_inst_id, 64'd2);
        check("redir_pc", 64'(bus.memreq_addr), 64'h100);
        advance();
        hold = 1'b0;
        wait_deliv(2, "redir_deliv_count");
        if (deliv.size() >= 2) begin
            check("redir_first_addr", 64'(deliv[0].addr), 64'h100);
            check("redir_first_id", deliv[0].id, 64'd2);
            check("redir_second_addr", 64'(deliv[1].addr), 64'h104);
        end

        // Redirect to the oldest live request while the queue is empty: no flush.
        do_reset();
        hold = 1'b1;
        bus.iresp_ready = 1'b1;
        tick();
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 32'h40;
        tick();
        bus.ireq_valid   = 1'b0;
        bus.memreq_ready = 1'b1;
        tick();
        bus.memreq_ready = 1'b0;
        bus.ireq_valid   = 1'b1;
        bus.ireq_addr    = 32'h40;
        settle();
        check("slow_memreq_valid", 64'(bus.memreq_valid), 64'd1);
        advance();
        bus.ireq_valid = 1'b0;
        settle();
        check("slow_id_unchanged", bus.iresp_inst_id, 64'd1);
        check("slow_pc_kept", 64'(bus.memreq_addr), 64'h44);
        advance();
        hold = 1'b0;
        wait_deliv(1, "slow_deliv_count");
        if (deliv.size() >= 1) begin
            check("slow_addr", 64'(deliv[0].addr), 64'h40);
            check("slow_id", deliv[0].id, 64'd1);
            check("slow_inst", 64'(deliv[0].inst), 64'(inst_of(32'h40)));
        end

        // Random redirects, memory stalls and back-pressure on the request side.
        do_reset();
        bus.iresp_ready = 1'b1;
        exp_next = 32'h0;
        total = 0;
        for (int i = 0; i < 600; i++) begin
            bus.memreq_ready = 1'($urandom_range(0, 1));
            hold             = ($urandom_range(0, 3) == 0);
            redir            = ($urandom_range(0, 15) == 0);
            tgt              = 32'($urandom_range(1, 255)) << 8;
            if (redir && pend.size() > 0 && $urandom_range(0, 1) == 1) tgt = pend[0].addr;
            bus.ireq_valid = redir;
            bus.ireq_addr  = tgt;
            tick();
            while (deliv.size() > 0) begin
                del_t d;
                d = deliv.pop_front();
                check("rand_addr", 64'(d.addr), 64'(exp_next));
                check("rand_inst", 64'(d.inst), 64'(inst_of(d.addr)));
                exp_next = d.addr + 32'd4;
                total++;
            end
            if (redir) exp_next = tgt;
        end
        bus.ireq_valid = 1'b0;
        check("rand_progress", 64'(total > 50), 64'd1);

        // Reset asserted with two requests in flight.
        do_reset();
        hold = 1'b1;
        bus.memreq_ready = 1'b1;
        bus.iresp_ready  = 1'b1;
        repeat (3) tick();
        bus.memreq_ready = 1'b0;
        check("mid_inflight", 64'(pend.size()), 64'd2);
        rst_n = 1'b0;
        tick();
        settle();
        check("mid_rst_memreq_valid", 64'(bus.memreq_valid), 64'd0);
        check("mid_rst_iresp_valid", 64'(bus.iresp_valid), 64'd0);
        check("mid_rst_inst_id", bus.iresp_inst_id, 64'd0);
        advance();
        rst_n = 1'b1;
        hold = 1'b0;
        deliv.delete();
        bus.memreq_ready = 1'b1;
        settle();
        check("mid_release_memreq_valid", 64'(bus.memreq_valid), 64'd0);
        advance();
        settle();
        check("mid_restart_valid", 64'(bus.memreq_valid), 64'd1);
        check("mid_restart_addr", 64'(bus.memreq_addr), 64'h0);
        advance();
        wait_deliv(1, "mid_deliv_count");
        if (deliv.size() >= 1) begin
            check("mid_first_addr", 64'(deliv[0].addr), 64'h0);
            check("mid_first_id", deliv[0].id, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
